// File: rtl/alu_test_pkg.sv
// Shared encodings for the ALU stimulus/response pair: OP codes, checker states, default width.
package alu_test_pkg;
  localparam int DEF_WIDTH = 7;
  localparam logic OP_NOT = 1'b0;
  localparam logic OP_SHR = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_e;
endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU: NOT or logical shift right by the full B value.
module alu_ref_model
  import alu_test_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] exp_y
);
  always_comb begin
    exp_y = ~a;
    if (op == OP_SHR) exp_y = (b >= WIDTH'(WIDTH)) ? '0 : (a >> b);
  end
endmodule

// File: rtl/alu_result_checker.sv
// Aligns reference results to the ALU latency and scores observed Y against them.
module alu_result_checker
  import alu_test_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LATENCY   = 1,
  parameter int NUM_TESTS = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             OP,
  input  logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             error,
  output logic             done,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_op,
  output logic [WIDTH-1:0] fail_y,
  output logic [WIDTH-1:0] fail_exp
);
  localparam int TW = $clog2(NUM_TESTS + 1);

  typedef struct packed {
    logic             vld;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_y;
  } stage_t;

  chk_state_e      state;
  logic [TW-1:0]   issued, checked, checked_nxt;
  logic [WIDTH-1:0] ref_exp;
  logic            accept, fire, mismatch;
  stage_t          in_st, cmp;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (.a(A), .b(B), .op(OP), .exp_y(ref_exp));

  // start blocks acceptance so the first vector of a run is the cycle after start
  assign accept = (state == RUN) && in_valid && !start && (issued < TW'(NUM_TESTS));
  assign in_st  = '{vld: accept, op: OP, a: A, b: B, exp_y: ref_exp};

  generate
    if (LATENCY == 0) begin : g_nopipe
      assign cmp = in_st;
    end else begin : g_pipe
      stage_t pipe [LATENCY];
      always_ff @(posedge clk) begin
        if (reset || start) begin
          for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= in_st;
          for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign cmp = pipe[LATENCY-1];
    end
  endgenerate

  assign fire        = cmp.vld && (state == RUN || state == DRAIN);
  assign mismatch    = fire && (Y != cmp.exp_y);
  assign checked_nxt = checked + TW'(fire);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      state    <= reset ? IDLE : RUN;
      issued   <= '0;
      checked  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      error    <= 1'b0;
      done     <= 1'b0;
      fail_a   <= '0;
      fail_b   <= '0;
      fail_op  <= 1'b0;
      fail_y   <= '0;
      fail_exp <= '0;
    end else begin
      checked <= checked_nxt;
      if (accept) issued <= issued + TW'(1);
      if (fire && !mismatch && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      if (mismatch) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        error <= 1'b1;
        if (!error) begin
          fail_a   <= cmp.a;
          fail_b   <= cmp.b;
          fail_op  <= cmp.op;
          fail_y   <= Y;
          fail_exp <= cmp.exp_y;
        end
      end
      case (state)
        RUN:   if (accept && issued == TW'(NUM_TESTS - 1)) state <= DRAIN;
        DRAIN: if (checked_nxt == TW'(NUM_TESTS)) begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized self-checking bench: a LATENCY=1 checker plus a LATENCY=0 saturating build.
module tb_alu_result_checker;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  // DUT 1: LATENCY=1, NUM_TESTS=2, CNT_W=8
  logic start1 = 0, in_valid1 = 0, OP1 = 0;
  logic [6:0] A1 = 0, B1 = 0, Y1 = 0;
  logic [7:0] pass_cnt1, fail_cnt1;
  logic error1, done1, fail_op1;
  logic [6:0] fail_a1, fail_b1, fail_y1, fail_exp1;

  // DUT 2: LATENCY=0, NUM_TESTS=5, CNT_W=2
  logic start2 = 0, in_valid2 = 0, OP2 = 0;
  logic [6:0] A2 = 0, B2 = 0, Y2 = 0;
  logic [1:0] pass_cnt2, fail_cnt2;
  logic error2, done2, fail_op2;
  logic [6:0] fail_a2, fail_b2, fail_y2, fail_exp2;

  alu_result_checker #(.WIDTH(7), .LATENCY(1), .NUM_TESTS(2), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1), .A(A1), .B(B1), .OP(OP1), .Y(Y1),
    .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1), .error(error1), .done(done1),
    .fail_a(fail_a1), .fail_b(fail_b1), .fail_op(fail_op1), .fail_y(fail_y1), .fail_exp(fail_exp1));

  alu_result_checker #(.WIDTH(7), .LATENCY(0), .NUM_TESTS(5), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .A(A2), .B(B2), .OP(OP2), .Y(Y2),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .error(error2), .done(done2),
    .fail_a(fail_a2), .fail_b(fail_b2), .fail_op(fail_op2), .fail_y(fail_y2), .fail_exp(fail_exp2));

  int tests_run = 0, tests_failed = 0;

  logic [6:0] va [8], vb [8], vy [8];
  logic       vop [8];
  int         nv;

  // Reference: NOT as 127-a, SHR as integer division by 2**b, zero when b >= 7
  function automatic logic [6:0] model(input logic [6:0] a, input logic [6:0] b, input logic op);
    int r;
    if (!op) r = 127 - int'(a);
    else if (int'(b) >= 7) r = 0;
    else r = int'(a) / (1 << b);
    return r[6:0];
  endfunction

  // Vector i on in_valid in cycle i, its Y one cycle later
  task automatic drive1(input bit do_start);
    if (do_start) begin
      @(posedge clk); #1 start1 = 1;
      @(posedge clk); #1 start1 = 0;
    end
    for (int i = 0; i <= nv; i++) begin
      in_valid1 = (i < nv);
      if (i < nv) begin A1 = va[i]; B1 = vb[i]; OP1 = vop[i]; end
      Y1 = (i > 0) ? vy[i-1] : 7'd0;
      @(posedge clk); #1;
    end
    in_valid1 = 0;
  endtask

  task automatic check1(input string name);
    int ep = 0, ef = 0, cyc = 0;
    logic [6:0] fa = 0, fb = 0, fy = 0, fe = 0, e;
    logic fo = 0;
    for (int k = 0; k < nv && k < 2; k++) begin
      e = model(va[k], vb[k], vop[k]);
      if (vy[k] === e) ep++;
      else begin
        if (ef == 0) begin fa = va[k]; fb = vb[k]; fo = vop[k]; fy = vy[k]; fe = e; end
        ef++;
      end
    end
    while (done1 !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    tests_run++;
    if (done1 !== 1'b1) begin tests_failed++; $display("FAIL %s done: got %b want 1", name, done1); end
    tests_run++;
    if (pass_cnt1 !== 8'(ep) || fail_cnt1 !== 8'(ef) || error1 !== (ef > 0)) begin
      tests_failed++;
      $display("FAIL %s counts: got pass=%0d fail=%0d err=%b want pass=%0d fail=%0d err=%b",
               name, pass_cnt1, fail_cnt1, error1, ep, ef, ef > 0);
    end
    tests_run++;
    if (fail_a1 !== fa || fail_b1 !== fb || fail_op1 !== fo || fail_y1 !== fy || fail_exp1 !== fe) begin
      tests_failed++;
      $display("FAIL %s capture: got a=%b b=%b op=%b y=%b exp=%b want a=%b b=%b op=%b y=%b exp=%b",
               name, fail_a1, fail_b1, fail_op1, fail_y1, fail_exp1, fa, fb, fo, fy, fe);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    tests_run++;
    if ({pass_cnt1, fail_cnt1, error1, done1, fail_a1, fail_b1, fail_op1, fail_y1, fail_exp1} !== '0) begin
      tests_failed++; $display("FAIL reset dut1: got pass=%0d fail=%0d err=%b done=%b want all 0",
                               pass_cnt1, fail_cnt1, error1, done1);
    end
    tests_run++;
    if ({pass_cnt2, fail_cnt2, error2, done2, fail_a2, fail_b2, fail_op2, fail_y2, fail_exp2} !== '0) begin
      tests_failed++; $display("FAIL reset dut2: got pass=%0d fail=%0d err=%b done=%b want all 0",
                               pass_cnt2, fail_cnt2, error2, done2);
    end
  endtask

  task automatic test_directed_pass();
    nv = 2;
    va[0] = 7'b1010101; vb[0] = 7'b0; vop[0] = 0; vy[0] = 7'b0101010;
    va[1] = 7'b1100110; vb[1] = 7'b0000011; vop[1] = 1; vy[1] = 7'b0001100;
    drive1(1);
    check1("directed_pass");
  endtask

  task automatic test_directed_fail();
    nv = 2;
    va[0] = 7'b1010101; vb[0] = 7'b0; vop[0] = 0; vy[0] = 7'b0101010;
    va[1] = 7'b1100110; vb[1] = 7'b0000011; vop[1] = 1; vy[1] = 7'b0001101;
    drive1(1);
    check1("directed_fail");
  endtask

  task automatic test_shift_range();
    nv = 2;
    va[0] = 7'b1111111; vb[0] = 7'b0000111; vop[0] = 1; vy[0] = 7'b0;
    va[1] = 7'b1111111; vb[1] = 7'b1000000; vop[1] = 1; vy[1] = 7'b0;
    drive1(1);
    check1("shift_range");
  endtask

  task automatic test_back_to_back();
    nv = 3;
    for (int i = 0; i < 3; i++) begin
      va[i] = 7'($urandom); vb[i] = 7'($urandom_range(0, 9)); vop[i] = 1'($urandom);
      vy[i] = model(va[i], vb[i], vop[i]);
    end
    vy[1] = vy[1] ^ 7'h10;
    drive1(1);
    check1("back_to_back");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      nv = 2;
      for (int i = 0; i < 2; i++) begin
        va[i] = 7'($urandom); vop[i] = 1'($urandom);
        vb[i] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 8));
        vy[i] = model(va[i], vb[i], vop[i]);
        if ($urandom_range(0, 2) == 0) vy[i] = vy[i] ^ 7'(1 << $urandom_range(0, 6));
      end
      drive1(1);
      check1($sformatf("random%0d", r));
    end
  endtask

  task automatic test_start_in_drain();
    @(posedge clk); #1 start1 = 1;
    @(posedge clk); #1 start1 = 0;
    in_valid1 = 1; A1 = 7'b0001111; B1 = 0; OP1 = 0;
    @(posedge clk); #1 A1 = 7'b0110000; B1 = 7'd2; OP1 = 1; Y1 = 7'b1110000;
    @(posedge clk); #1 in_valid1 = 0; Y1 = 7'b1111111; start1 = 1;
    @(posedge clk); #1 start1 = 0;
    tests_run++;
    if (pass_cnt1 !== 0 || fail_cnt1 !== 0 || error1 !== 0 || done1 !== 0 || fail_y1 !== 0) begin
      tests_failed++;
      $display("FAIL start_in_drain clear: got pass=%0d fail=%0d err=%b done=%b fy=%b want all 0",
               pass_cnt1, fail_cnt1, error1, done1, fail_y1);
    end
    nv = 2;
    va[0] = 7'b0011001; vb[0] = 7'd1; vop[0] = 1; vy[0] = 7'b0001100;
    va[1] = 7'b0000000; vb[1] = 7'd0; vop[1] = 0; vy[1] = 7'b1111110;
    drive1(0);
    check1("start_in_drain_rerun");
  endtask

  task automatic test_reset_midrun();
    @(posedge clk); #1 start1 = 1;
    @(posedge clk); #1 start1 = 0;
    in_valid1 = 1; A1 = 7'b1000000; B1 = 7'd6; OP1 = 1;
    @(posedge clk); #1 in_valid1 = 0; Y1 = 7'b0000001;
    @(posedge clk); #1;
    tests_run++;
    if (pass_cnt1 !== 8'd1) begin tests_failed++; $display("FAIL midrun_pre pass: got %0d want 1", pass_cnt1); end
    reset = 1;
    @(posedge clk); #1 reset = 0;
    tests_run++;
    if ({pass_cnt1, fail_cnt1, error1, done1, fail_a1, fail_b1, fail_op1, fail_y1, fail_exp1} !== '0) begin
      tests_failed++; $display("FAIL midrun_reset: got pass=%0d fail=%0d err=%b done=%b want all 0",
                               pass_cnt1, fail_cnt1, error1, done1);
    end
    // IDLE must ignore vectors until the next start
    in_valid1 = 1; A1 = 7'b0000000; OP1 = 0; Y1 = 7'b1111111;
    repeat (4) @(posedge clk);
    #1 in_valid1 = 0;
    tests_run++;
    if (pass_cnt1 !== 0 || fail_cnt1 !== 0 || done1 !== 0) begin
      tests_failed++; $display("FAIL idle_ignore: got pass=%0d fail=%0d done=%b want 0 0 0",
                               pass_cnt1, fail_cnt1, done1);
    end
  endtask

  task automatic test_saturate();
    logic [6:0] a0 = 0, b0 = 0, e0 = 0;
    logic o0 = 0;
    int cyc = 0;
    @(posedge clk); #1 start2 = 1;
    @(posedge clk); #1 start2 = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1; A2 = 7'($urandom); B2 = 7'($urandom_range(0, 9)); OP2 = 1'($urandom);
      Y2 = model(A2, B2, OP2) ^ 7'h01;
      if (i == 0) begin a0 = A2; b0 = B2; o0 = OP2; e0 = model(A2, B2, OP2); end
      @(posedge clk); #1;
    end
    in_valid2 = 0;
    while (done2 !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    tests_run++;
    if (done2 !== 1'b1) begin tests_failed++; $display("FAIL sat done: got %b want 1", done2); end
    tests_run++;
    if (fail_cnt2 !== 2'd3 || pass_cnt2 !== 2'd0 || error2 !== 1'b1) begin
      tests_failed++; $display("FAIL sat counts: got fail=%0d pass=%0d err=%b want 3 0 1",
                               fail_cnt2, pass_cnt2, error2);
    end
    tests_run++;
    if (fail_a2 !== a0 || fail_b2 !== b0 || fail_op2 !== o0 || fail_exp2 !== e0 || fail_y2 !== (e0 ^ 7'h01)) begin
      tests_failed++;
      $display("FAIL sat capture: got a=%b b=%b op=%b y=%b exp=%b want a=%b b=%b op=%b y=%b exp=%b",
               fail_a2, fail_b2, fail_op2, fail_y2, fail_exp2, a0, b0, o0, e0 ^ 7'h01, e0);
    end
  endtask

  initial begin
    test_reset();
    test_directed_pass();
    test_directed_fail();
    test_shift_range();
    test_back_to_back();
    test_random();
    test_start_in_drain();
    test_reset_midrun();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Response-side counterpart to the ALU stimulus controller. Captures each applied operand set (A, B, OP), computes the expected ALU result with an internal reference model, aligns it to the ALU's result latency, and compares it against the observed result Y. Maintains pass/fail counters, a sticky error flag and a first-failure capture, and signals done once NUM_TESTS results have been checked.

Parameters:
WIDTH, 7, operand/result width in bits.
LATENCY, 1, cycles from operand valid to ALU result Y valid (0 = same cycle); range 0..8.
NUM_TESTS, 2, number of vectors per run.
CNT_W, 8, width of the pass/fail counters.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; clears results and begins a run.
in_valid  input  1  A/B/OP are an applied test vector this cycle.
A  input  WIDTH  ALU operand A.
B  input  WIDTH  ALU operand B (shift amount for SHR).
OP  input  1  0 = NOT, 1 = SHR.
Y  input  WIDTH  ALU result; sampled LATENCY cycles after the matching in_valid.
pass_cnt  output  CNT_W  matching results this run.
fail_cnt  output  CNT_W  mismatching results this run.
error  output  1  sticky; set on first mismatch of the run.
done  output  1  high while in DONE.
fail_a, fail_b  output  WIDTH  operands of the first failing vector.
fail_op  output  1  OP of the first failing vector.
fail_y, fail_exp  output  WIDTH  observed and expected values of the first failure.

Behaviour:
- Single clock; reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset: state = IDLE; all outputs, counters, the capture registers and the pipeline valid bits are 0.
- Reference model:
  - NOT: exp = ~A (WIDTH bits).
  - SHR: exp = A >> B (logical shift on the full B value); B >= WIDTH gives 0.
- Alignment pipeline: LATENCY stages of {valid, A, B, OP, exp}, loaded on an accepted in_valid.
  - The compare stage uses the pipeline output, or the current inputs when LATENCY = 0.
  - The compare fires only when the aligned valid bit is 1.
- State machine:
  - IDLE: in_valid is ignored. start -> RUN.
  - RUN: an in_valid is accepted while issued < NUM_TESTS, and each acceptance increments issued. When issued reaches NUM_TESTS, go to DRAIN in the same cycle as the last acceptance. Extra in_valid pulses are ignored.
  - DRAIN: no acceptance. Compares continue; when checked == NUM_TESTS -> DONE.
  - DONE: done = 1; hold until start -> RUN.
- On each compare:
  - Match: pass_cnt += 1.
  - Mismatch: fail_cnt += 1 and error = 1. If error was 0 beforehand, load the fail_* registers; later failures never overwrite them.
  - Both counters saturate at all-ones. checked increments on every compare.
- Entering RUN from any state:
  - Clears the counters, issued, checked, error, fail_* and all pipeline valid bits. Any in-flight compare in that cycle is discarded.
  - start takes priority over any compare or acceptance in the same cycle.
  - An in_valid in the start cycle itself is not accepted; the first accepted vector is in the cycle after start.
- Reset in mid-run returns to IDLE with everything cleared; no partial results are retained.
- Outputs are registered, with no combinational paths from inputs to outputs.

Decomposition:
- Package alu_test_pkg:
  - OP encodings OP_NOT = 1'b0 and OP_SHR = 1'b1.
  - Checker state enum: IDLE, RUN, DRAIN, DONE.
  - Default WIDTH constant.
- Sub-module alu_ref_model: purely combinational (A, B, OP) -> exp. It is shared with future ALU benches and instantiated once at the pipeline input.

Test Plan:
- Reset, then LATENCY = 1. start; then in_valid with A = 1010101, OP = 0, followed by Y = 0101010 one cycle later. Next, A = 1100110, B = 0000011, OP = 1, followed by Y = 0001100. Required: pass_cnt = 2, fail_cnt = 0, error = 0, done = 1 one cycle after the second compare.
- Same sequence but the second Y = 0001101. Required: pass_cnt = 1, fail_cnt = 1, error = 1, fail_a = 1100110, fail_b = 0000011, fail_op = 1, fail_y = 0001101, fail_exp = 0001100.
- SHR with A = 1111111 and B = 0000111, Y = 0. Required: pass. Then B = 1000000, Y = 0. Required: pass. This covers the shift-out-of-range boundary.
- NUM_TESTS = 2 with three back-to-back in_valid pulses. Required: the third is ignored, the FSM goes to DRAIN after the second, and checked = 2.
- start pulsed while in DRAIN with a compare pending. Required: counters = 0, error = 0, the pending compare is not counted, and state = RUN. Reset asserted mid-run. Required: all outputs 0 and state = IDLE on the next edge.
- LATENCY = 0 build with CNT_W = 2 and NUM_TESTS = 5, all mismatches. Required: fail_cnt saturates at 3, and fail_* holds the first vector.
